// File: rtl/trafficlight_pkg.sv
// Shared types and constants for the pedestrian-request traffic light.
// The state enum, LED colour codes and phase-order helpers live here.
package trafficlight_pkg;

    typedef enum logic [1:0] {
        S_RED,
        S_YELLOW_UP,
        S_GREEN,
        S_YELLOW_DN
    } tl_state_t;

    localparam logic [2:0] RGB_RED    = 3'b100;
    localparam logic [2:0] RGB_YELLOW = 3'b110;
    localparam logic [2:0] RGB_GREEN  = 3'b010;

    // Successor of a timed phase; RED is left only on a request, never by timeout.
    function automatic tl_state_t next_phase(input tl_state_t s);
        tl_state_t n;
        n = S_RED;
        unique case (s)
            S_YELLOW_UP: n = S_GREEN;
            S_GREEN:     n = S_YELLOW_DN;
            S_YELLOW_DN: n = S_RED;
            default:     n = S_RED;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] rgb_of(input tl_state_t s);
        logic [2:0] c;
        c = RGB_RED;
        unique case (s)
            S_RED:       c = RGB_RED;
            S_YELLOW_UP: c = RGB_YELLOW;
            S_GREEN:     c = RGB_GREEN;
            S_YELLOW_DN: c = RGB_YELLOW;
            default:     c = RGB_RED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/trafficlight.sv
// Pedestrian-request traffic light: rests on RED, a registered button request
// runs YELLOW -> GREEN -> YELLOW -> RED with PHASE_CYCLES clocks per lit phase.
module trafficlight
    import trafficlight_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 10
) (
    input  logic       clk,
    input  logic       resn,
    input  logic       btn,
    output logic [2:0] rgb
);

    localparam int unsigned CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    logic             btn_q;
    tl_state_t        state;
    tl_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (resn) begin
            btn_q <= 1'b0;
            state <= S_RED;
            cnt   <= '0;
        end else begin
            btn_q <= btn;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt defaults to 0 so it is cleared both in RED and on every phase change;
    // requests are looked at only in RED, so presses mid-sequence are dropped.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        unique case (state)
            S_RED: begin
                if (btn_q) begin
                    state_nxt = S_YELLOW_UP;
                end
            end
            default: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = next_phase(state);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        rgb = rgb_of(state);
    end

endmodule

// File: tb/tb_trafficlight.sv
// Self-checking bench for trafficlight: directed scenarios plus random presses,
// compared every cycle against a sequence-age model of the light.
`timescale 1ns/1ps
module tb_trafficlight;

    localparam int P = 10;

    logic       clk;
    logic       resn;
    logic       btn;
    logic [2:0] rgb;

    int errors;
    int checks;

    // Reference: request register plus age of the running sequence (-1 = resting on RED).
    int ref_btn_q;
    int ref_age;

    trafficlight #(.PHASE_CYCLES(P)) dut (
        .clk  (clk),
        .resn (resn),
        .btn  (btn),
        .rgb  (rgb)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    function automatic logic [2:0] ref_rgb(input int age);
        if (age < 0)               return 3'b100;
        else if ((age / P) == 1)   return 3'b010;
        else                       return 3'b110;
    endfunction

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs for one rising edge, advance the model, then check at the falling edge.
    task automatic step(input logic b, input logic r, input string tag);
        btn  = b;
        resn = r;
        @(posedge clk);
        if (r) begin
            ref_age   = -1;
            ref_btn_q = 0;
        end else begin
            if (ref_age < 0) begin
                if (ref_btn_q != 0) ref_age = 0;
            end else begin
                ref_age++;
                if (ref_age >= 3 * P) ref_age = -1;
            end
            ref_btn_q = b ? 1 : 0;
        end
        @(negedge clk);
        check(tag, rgb, ref_rgb(ref_age));
        checks++;
        assert (rgb === 3'b100 || rgb === 3'b110 || rgb === 3'b010) else begin
            errors++;
            $error("FAIL legal_%s got=%b exp=one_of_100_110_010", tag, rgb);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        ref_btn_q = 0;
        ref_age   = -1;
        btn       = 1'b0;
        resn      = 1'b1;

        // 1. Reset then idle.
        step(1'b0, 1'b1, "reset");
        check("reset_red", rgb, 3'b100);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, "idle");

        // 2. Single pulse: explicit phase boundaries plus model.
        step(1'b1, 1'b0, "pulse_E");
        for (int k = 1; k <= 80; k++) begin
            step(1'b0, 1'b0, "pulse_seq");
            if (k == 1)  check("first_yellow", rgb, 3'b110);
            if (k == 10) check("last_yellow_up", rgb, 3'b110);
            if (k == 11) check("first_green", rgb, 3'b010);
            if (k == 20) check("last_green", rgb, 3'b010);
            if (k == 21) check("first_yellow_dn", rgb, 3'b110);
            if (k == 30) check("last_yellow_dn", rgb, 3'b110);
            if (k == 31) check("back_red", rgb, 3'b100);
            if (k == 80) check("still_red", rgb, 3'b100);
        end

        // 3. Presses during GREEN and YELLOW_DN are ignored.
        step(1'b1, 1'b0, "ign_E");
        for (int k = 1; k <= 60; k++) begin
            step((k == 14 || k == 15 || k == 24) ? 1'b1 : 1'b0, 1'b0, "ignore");
            if (k == 31) check("ign_back_red", rgb, 3'b100);
            if (k == 60) check("ign_no_second", rgb, 3'b100);
        end

        // 4. Button held: back-to-back sequences with one RED cycle between.
        for (int k = 0; k < 100; k++) step(1'b1, 1'b0, "held");
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0, "held_drain");

        // 5. Reset at edge 5 of GREEN, then reset with btn high on the same edge.
        step(1'b1, 1'b0, "rst_E");
        for (int k = 1; k <= 14; k++) step(1'b0, 1'b0, "rst_pre");
        check("rst_in_green", rgb, 3'b010);
        step(1'b0, 1'b1, "rst_mid");
        check("rst_mid_red", rgb, 3'b100);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, "rst_stay");
        step(1'b1, 1'b0, "rst2_E");
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, "rst2_pre");
        step(1'b1, 1'b1, "rst_btn");
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, "rst_btn_after");

        // 6. Random presses with occasional reset.
        for (int k = 0; k < 600; k++)
            step(($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, "random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
